// File: rtl/id_ex_pkg.sv
// ID->EX stage shared types: decoded control bundle, bubble constant and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int ALUOP_W_DEF    = 3;
    localparam int NUM_SRC_DEF    = 3;
    localparam int CNT_W_DEF      = 8;

    // Decoded control bundle, MSB first: mem_to_reg .. reg_write
    typedef struct packed {
        logic                   mem_to_reg;
        logic                   mem_read;
        logic                   mem_write;
        logic [ALUOP_W_DEF-1:0] alu_op;
        logic                   alu_src;
        logic                   reg_write;
    } ctrl_t;

    // Bubble: no memory access, no register write-back
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// ID->EX bus: decode-side push channel, EX-side pop channel, flush and stall counter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both channels; in_ready qualifies in_valid.
interface id_ex_pipe_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int CNT_W      = 8
);
    import id_ex_pkg::*;

    logic                      flush;

    logic                      in_valid;
    logic                      in_ready;
    ctrl_t                     in_ctrl;
    logic [DATA_W-1:0]         in_pc;
    logic [NUM_SRC*DATA_W-1:0] in_rd;
    logic [REG_ADDR_W-1:0]     in_dst;
    logic [DATA_W-1:0]         in_imm;

    logic                      out_valid;
    logic                      out_ready;
    ctrl_t                     out_ctrl;
    logic [DATA_W-1:0]         out_pc;
    logic [NUM_SRC*DATA_W-1:0] out_rd;
    logic [REG_ADDR_W-1:0]     out_dst;
    logic [DATA_W-1:0]         out_imm;

    logic [CNT_W-1:0]          stall_cnt;

    // Pipeline stage side
    modport slave (
        input  flush,
        input  in_valid, in_ctrl, in_pc, in_rd, in_dst, in_imm,
        output in_ready,
        output out_valid, out_ctrl, out_pc, out_rd, out_dst, out_imm,
        input  out_ready,
        output stall_cnt
    );

    // Decode/EX environment side
    modport master (
        output flush,
        output in_valid, in_ctrl, in_pc, in_rd, in_dst, in_imm,
        input  in_ready,
        input  out_valid, out_ctrl, out_pc, out_rd, out_dst, out_imm,
        output out_ready,
        input  stall_cnt
    );

endinterface

// File: rtl/id_ex_pipe_stage_pipe_slot.sv
// One ID->EX payload register with its valid bit; load and clear controls, clear wins.
// Latency: one falling edge from load to q_valid.
// Backpressure: none inside; the parent decides when to load or clear.
module pipe_slot
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      clear,
    input  ctrl_t                     d_ctrl,
    input  logic [DATA_W-1:0]         d_pc,
    input  logic [NUM_SRC*DATA_W-1:0] d_rd,
    input  logic [REG_ADDR_W-1:0]     d_dst,
    input  logic [DATA_W-1:0]         d_imm,
    output logic                      q_valid,
    output ctrl_t                     q_ctrl,
    output logic [DATA_W-1:0]         q_pc,
    output logic [NUM_SRC*DATA_W-1:0] q_rd,
    output logic [REG_ADDR_W-1:0]     q_dst,
    output logic [DATA_W-1:0]         q_imm
);

    // Occupancy: clear (flush or pop) beats a load in the same edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
        end
    end

    // Payload: captured only by a load that survives; otherwise holds its last value
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_ctrl <= CTRL_NOP;
            q_pc   <= '0;
            q_rd   <= '0;
            q_dst  <= '0;
            q_imm  <= '0;
        end else if (load && !clear) begin
            q_ctrl <= d_ctrl;
            q_pc   <= d_pc;
            q_rd   <= d_rd;
            q_dst  <= d_dst;
            q_imm  <= d_imm;
        end
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Elastic ID->EX pipeline register with flush, bubble masking and saturating stall counter.
// Latency: one falling edge from accept to out_valid; full throughput on simultaneous pop/push.
// Backpressure: in_ready = !out_valid || out_ready; with ID_EX_SKID_BUFFER_EN a skid entry makes it registered (!skid_valid).
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ALUOP_W    = ALUOP_W_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_pipe_stage_if.slave bus
);

    // The control bundle layout is fixed by the shared package
    if (ALUOP_W != ALUOP_W_DEF) begin : g_aluop_chk
        $error("id_ex_pipe_stage: ALUOP_W must match id_ex_pkg::ALUOP_W_DEF");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                      in_ready;
    logic                      push;
    logic                      pop;

    logic                      h_load;
    logic                      h_clear;
    ctrl_t                     hd_ctrl;
    logic [DATA_W-1:0]         hd_pc;
    logic [NUM_SRC*DATA_W-1:0] hd_rd;
    logic [REG_ADDR_W-1:0]     hd_dst;
    logic [DATA_W-1:0]         hd_imm;

    logic                      h_valid;
    ctrl_t                     h_ctrl;
    logic [DATA_W-1:0]         h_pc;
    logic [NUM_SRC*DATA_W-1:0] h_rd;
    logic [REG_ADDR_W-1:0]     h_dst;
    logic [DATA_W-1:0]         h_imm;

    logic [CNT_W-1:0]          stall_cnt;

    assign pop  = h_valid && bus.out_ready;
    assign push = bus.in_valid && in_ready;

`ifdef ID_EX_SKID_BUFFER_EN
    logic                      s_load;
    logic                      s_clear;
    logic                      s_valid;
    ctrl_t                     s_ctrl;
    logic [DATA_W-1:0]         s_pc;
    logic [NUM_SRC*DATA_W-1:0] s_rd;
    logic [REG_ADDR_W-1:0]     s_dst;
    logic [DATA_W-1:0]         s_imm;

    // A full skid slot is the only thing that blocks decode, so in_ready is a flop output
    assign in_ready = !s_valid;

    // With the skid occupied no push can happen; the head refills from the skid on pop.
    // Otherwise the head takes the push when it is empty or being popped.
    assign h_load  = s_valid ? pop : (push && (!h_valid || pop));
    assign h_clear = bus.flush || (pop && !h_load);
    // A push that arrives while the head is stalled lands in the skid
    assign s_load  = push && h_valid && !pop;
    assign s_clear = bus.flush || (s_valid && pop);

    assign hd_ctrl = s_valid ? s_ctrl : bus.in_ctrl;
    assign hd_pc   = s_valid ? s_pc   : bus.in_pc;
    assign hd_rd   = s_valid ? s_rd   : bus.in_rd;
    assign hd_dst  = s_valid ? s_dst  : bus.in_dst;
    assign hd_imm  = s_valid ? s_imm  : bus.in_imm;

    pipe_slot #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_SRC    (NUM_SRC)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .d_ctrl  (bus.in_ctrl),
        .d_pc    (bus.in_pc),
        .d_rd    (bus.in_rd),
        .d_dst   (bus.in_dst),
        .d_imm   (bus.in_imm),
        .q_valid (s_valid),
        .q_ctrl  (s_ctrl),
        .q_pc    (s_pc),
        .q_rd    (s_rd),
        .q_dst   (s_dst),
        .q_imm   (s_imm)
    );
`else
    // Single entry: accept when empty or when the current entry leaves this edge
    assign in_ready = !h_valid || bus.out_ready;

    assign h_load  = push;
    assign h_clear = bus.flush || (pop && !push);

    assign hd_ctrl = bus.in_ctrl;
    assign hd_pc   = bus.in_pc;
    assign hd_rd   = bus.in_rd;
    assign hd_dst  = bus.in_dst;
    assign hd_imm  = bus.in_imm;
`endif

    pipe_slot #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_SRC    (NUM_SRC)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (h_load),
        .clear   (h_clear),
        .d_ctrl  (hd_ctrl),
        .d_pc    (hd_pc),
        .d_rd    (hd_rd),
        .d_dst   (hd_dst),
        .d_imm   (hd_imm),
        .q_valid (h_valid),
        .q_ctrl  (h_ctrl),
        .q_pc    (h_pc),
        .q_rd    (h_rd),
        .q_dst   (h_dst),
        .q_imm   (h_imm)
    );

    // Count edges where EX holds back a valid entry; sticks at max, only rst clears it
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (h_valid && !bus.out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = h_valid;
    // Bubbles never carry memory or write-back side effects
    assign bus.out_ctrl  = h_valid ? h_ctrl : CTRL_NOP;
    assign bus.out_pc    = h_pc;
    assign bus.out_rd    = h_rd;
    assign bus.out_dst   = h_dst;
    assign bus.out_imm   = h_imm;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: vector table, directed corner sequences, random vs queue model.
// Latency: checks one falling edge from accept to output.
// Backpressure: model queue of depth 1 (or 2 with ID_EX_SKID_BUFFER_EN).
module tb_id_ex_pipe_stage;
    import id_ex_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NS = 3;
    localparam int CW = 4;
`ifdef ID_EX_SKID_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_SAT = (1 << CW) - 1;

    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    id_ex_pipe_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .CNT_W(CW)) bus ();

    id_ex_pipe_stage #(
        .DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(3), .NUM_SRC(NS), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an ordered queue of whole instructions
    typedef struct {
        ctrl_t          ctrl;
        logic [DW-1:0]  pc;
        logic [NS*DW-1:0] rd;
        logic [AW-1:0]  dst;
        logic [DW-1:0]  imm;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   cur_fl, cur_iv, cur_ordy;
    ent_t cur_e;

    function automatic ent_t mk(input logic [DW-1:0] pc, input ctrl_t c);
        ent_t e;
        e.ctrl = c;
        e.pc   = pc;
        e.rd   = {pc + 32'd2, pc + 32'd1, pc ^ 32'hA5A5_0000};
        e.dst  = pc[5:2];
        e.imm  = ~pc;
        return e;
    endfunction

    function automatic bit m_ready(input bit ordy);
        if (DEPTH == 1) return (q.size() == 0) || ordy;
        return q.size() < DEPTH;
    endfunction

    task automatic drive(input bit fl, input bit iv, input bit ordy, input ent_t e);
        cur_fl = fl; cur_iv = iv; cur_ordy = ordy; cur_e = e;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_ctrl   = e.ctrl;
        bus.in_pc     = e.pc;
        bus.in_rd     = e.rd;
        bus.in_dst    = e.dst;
        bus.in_imm    = e.imm;
    endtask

    // Apply one falling edge to the model using the inputs present at that edge
    task automatic m_step();
        bit rdy;
        rdy = m_ready(cur_ordy);
        if (q.size() > 0 && !cur_ordy && m_cnt < CNT_SAT) m_cnt++;
        if (cur_fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && cur_ordy) void'(q.pop_front());
            if (cur_iv && rdy) q.push_back(cur_e);
        end
    endtask

    task automatic m_check();
        chk("out_valid", bus.out_valid, q.size() > 0);
        chk("in_ready", bus.in_ready, m_ready(cur_ordy));
        chk("stall_cnt", bus.stall_cnt, m_cnt);
        if (q.size() > 0) begin
            chk("out_ctrl", bus.out_ctrl, q[0].ctrl);
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_rd", bus.out_rd, q[0].rd);
            chk("out_dst", bus.out_dst, q[0].dst);
            chk("out_imm", bus.out_imm, q[0].imm);
        end else begin
            chk("out_ctrl_bubble", bus.out_ctrl, 0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        m_step();
        #1;
        m_check();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- vector table
    typedef struct {
        bit            fl, iv, ordy;
        logic [DW-1:0] pc;
        logic [7:0]    ctrl;
        bit            e_v;
        logic [DW-1:0] e_pc;
        logic [7:0]    e_ctrl;
        bit            e_rdy;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        ent_t nop_e;
        nop_e = mk('0, CTRL_NOP);

        //         fl iv or  pc          ctrl   v  exp_pc      exp_ctl rdy cnt
        vt[0] = '{0, 1, 1, 32'h100, 8'h01, 1, 32'h100, 8'h01, 1, 0};
        vt[1] = '{0, 1, 1, 32'h104, 8'h03, 1, 32'h104, 8'h03, 1, 0};
        vt[2] = '{0, 1, 1, 32'h108, 8'h5C, 1, 32'h108, 8'h5C, 1, 0};
        vt[3] = '{0, 0, 1, 32'h10C, 8'h00, 0, 32'h0,   8'h00, 1, 0};
        vt[4] = '{0, 0, 1, 32'h110, 8'h20, 0, 32'h0,   8'h00, 1, 0};
        vt[5] = '{0, 1, 1, 32'h300, 8'h21, 1, 32'h300, 8'h21, 1, 0};
        vt[6] = '{1, 1, 1, 32'h304, 8'h01, 0, 32'h0,   8'h00, 1, 0};
        vt[7] = '{0, 0, 1, 32'h304, 8'h01, 0, 32'h0,   8'h00, 1, 0};

        // ---- reset state (asynchronous, before any edge)
        rst = 1'b1;
        drive(0, 0, 1, nop_e);
        q.delete();
        m_cnt = 0;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_ctrl", bus.out_ctrl, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_rd", bus.out_rd, 0);
        chk("rst_out_dst", bus.out_dst, 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        repeat (2) @(posedge clk);
        rst = 1'b0;
        drive(0, 0, 0, nop_e);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // ---- table: stream, bubble masking, flush beats concurrent push
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].ordy, mk(vt[i].pc, ctrl_t'(vt[i].ctrl)));
            @(negedge clk);
            m_step();
            #1;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, vt[i].e_v);
            chk($sformatf("vec%0d_ctrl", i), bus.out_ctrl, vt[i].e_ctrl);
            if (vt[i].e_v) chk($sformatf("vec%0d_pc", i), bus.out_pc, vt[i].e_pc);
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_cnt", i), bus.stall_cnt, vt[i].e_cnt);
        end

        // ---- stall hold: 0x200 held bit-stable for 5 stalled edges, then popped once
        drive(0, 1, 1, mk(32'h200, ctrl_t'(8'h01)));
        cycle();
        drive(0, 0, 0, nop_e);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_pc", bus.out_pc, 32'h200);
            chk("stall_ctrl", bus.out_ctrl, 8'h01);
            chk("stall_in_ready", bus.in_ready, (DEPTH == 1) ? 1'b0 : 1'b1);
        end
        chk("stall_cnt5", bus.stall_cnt, 5);
        drive(0, 0, 1, nop_e);
        cycle();
        chk("release_valid", bus.out_valid, 0);
        chk("release_cnt", bus.stall_cnt, 5);

        // ---- reset in the middle of a stall
        drive(0, 1, 1, mk(32'h500, ctrl_t'(8'h20)));
        cycle();
        drive(0, 0, 0, nop_e);
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_ctrl", bus.out_ctrl, 0);
        chk("midrst_pc", bus.out_pc, 0);
        chk("midrst_cnt", bus.stall_cnt, 0);
        q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        #1;

        // ---- saturation: 20 stalled edges stick at 15, flush keeps it, rst clears it
        drive(0, 1, 1, mk(32'h600, ctrl_t'(8'h01)));
        cycle();
        drive(0, 0, 0, nop_e);
        repeat (20) cycle();
        chk("sat_cnt", bus.stall_cnt, CNT_SAT);
        drive(1, 0, 0, nop_e);
        cycle();
        chk("sat_flush_valid", bus.out_valid, 0);
        chk("sat_flush_cnt", bus.stall_cnt, CNT_SAT);
        do_reset();
        chk("sat_rst_cnt", bus.stall_cnt, 0);

`ifdef ID_EX_SKID_BUFFER_EN
        // ---- skid: second push lands in skid while EX stalls, order kept
        drive(0, 1, 1, mk(32'h400, ctrl_t'(8'h01)));
        cycle();
        chk("skid_pc0", bus.out_pc, 32'h400);
        drive(0, 1, 0, mk(32'h404, ctrl_t'(8'h03)));
        #1;
        chk("skid_rdy_before", bus.in_ready, 1);
        cycle();
        chk("skid_pc0_held", bus.out_pc, 32'h400);
        chk("skid_full_rdy", bus.in_ready, 0);
        drive(0, 1, 0, mk(32'h408, ctrl_t'(8'h01)));
        cycle();
        chk("skid_no_accept_pc", bus.out_pc, 32'h400);
        drive(0, 0, 1, nop_e);
        cycle();
        chk("skid_pc1", bus.out_pc, 32'h404);
        chk("skid_pc1_valid", bus.out_valid, 1);
        chk("skid_rdy_after", bus.in_ready, 1);
        cycle();
        chk("skid_drained", bus.out_valid, 0);
        do_reset();
`endif

        // ---- random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            ent_t e;
            e.ctrl = ctrl_t'($urandom_range(0, 255));
            e.pc   = $urandom;
            e.rd   = {$urandom, $urandom, $urandom};
            e.dst  = AW'($urandom_range(0, 15));
            e.imm  = $urandom;
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), e);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
